// File: rtl/ntr_cmd_sequencer.sv
// NTR cartridge bus slave command sequencer.
// Captures the 8-byte command on synchronized ntr_clk rises while ntr_cs1 is
// low, then answers on ntr_clk falls with the chip ID, header ROM bytes or FFs.
module ntr_cmd_sequencer #(
    parameter logic [31:0] CHIP_ID     = 32'h00001FC2,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ntr_clk,
    input  logic              ntr_cs1,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic [ADDR_W-1:0] hdr_addr,
    input  logic [7:0]        hdr_data,
    output logic [63:0]       cmd,
    output logic              cmd_valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Synchronizer chains and edge-detect history
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   clk_prev;
    logic                   cs_prev;

    logic clk_now;
    logic cs_now;
    logic clk_rise;
    logic clk_fall;
    logic cs_rise;
    logic cs_fall;

    // Architectural state and its next values
    state_t             state;
    state_t             state_nxt;
    logic [55:0]        shift_reg;
    logic [55:0]        shift_nxt;
    logic [2:0]         byte_cnt;
    logic [2:0]         byte_cnt_nxt;
    logic [15:0]        resp_cnt;
    logic [15:0]        resp_cnt_nxt;
    logic [7:0]         data_out_nxt;
    logic               data_oe_nxt;
    logic [ADDR_W-1:0]  hdr_addr_nxt;
    logic [63:0]        cmd_nxt;
    logic               cmd_valid_nxt;
    logic               busy_nxt;
    logic [7:0]         chip_byte;

    // Synchronize the raw bus pins and remember the previous synchronized level.
    // The chains reset to 0 (selected, clock low) so that a cs1 still held low
    // when reset releases never looks like a fresh fall; only a later real
    // fall starts a transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '0;
            cs_sync  <= '0;
            clk_prev <= 1'b0;
            cs_prev  <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ntr_clk};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], ntr_cs1};
            clk_prev <= clk_sync[SYNC_STAGES-1];
            cs_prev  <= cs_sync[SYNC_STAGES-1];
        end
    end

    // Single-cycle edge pulses from the synchronized levels
    always_comb begin
        clk_now  = clk_sync[SYNC_STAGES-1];
        cs_now   = cs_sync[SYNC_STAGES-1];
        clk_rise = clk_now & ~clk_prev;
        clk_fall = ~clk_now & clk_prev;
        cs_rise  = cs_now & ~cs_prev;
        cs_fall  = ~cs_now & cs_prev;
    end

    // Chip ID byte selected by the low bits of the response counter, LSB first
    always_comb begin
        chip_byte = CHIP_ID[{resp_cnt[1:0], 3'b000} +: 8];
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            byte_cnt  <= '0;
            resp_cnt  <= '0;
            data_out  <= 8'hFF;
            data_oe   <= 1'b0;
            hdr_addr  <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            byte_cnt  <= byte_cnt_nxt;
            resp_cnt  <= resp_cnt_nxt;
            data_out  <= data_out_nxt;
            data_oe   <= data_oe_nxt;
            hdr_addr  <= hdr_addr_nxt;
            cmd       <= cmd_nxt;
            cmd_valid <= cmd_valid_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state and output decode; a cs1 rise overrides any clock edge
    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift_reg;
        byte_cnt_nxt  = byte_cnt;
        resp_cnt_nxt  = resp_cnt;
        data_out_nxt  = data_out;
        data_oe_nxt   = data_oe;
        hdr_addr_nxt  = hdr_addr;
        cmd_nxt       = cmd;
        cmd_valid_nxt = 1'b0;
        busy_nxt      = busy;

        if (cs_rise) begin
            // End of transaction: release the bus; a partial command is dropped
            state_nxt    = IDLE;
            data_oe_nxt  = 1'b0;
            busy_nxt     = 1'b0;
            data_out_nxt = 8'hFF;
        end else begin
            case (state)
                IDLE: begin
                    data_oe_nxt = 1'b0;
                    busy_nxt    = 1'b0;
                    // A clock rise coinciding with the cs1 fall is not sampled
                    if (cs_fall) begin
                        state_nxt    = CMD;
                        busy_nxt     = 1'b1;
                        byte_cnt_nxt = '0;
                    end
                end

                CMD: begin
                    if (clk_rise) begin
                        shift_nxt    = {shift_reg[47:0], data_in};
                        byte_cnt_nxt = byte_cnt + 3'd1;
                        if (byte_cnt == 3'd7) begin
                            cmd_nxt       = {shift_reg, data_in};
                            cmd_valid_nxt = 1'b1;
                            resp_cnt_nxt  = '0;
                            hdr_addr_nxt  = '0;
                            state_nxt     = RESP;
                        end
                    end
                end

                RESP: begin
                    if (clk_fall) begin
                        data_oe_nxt  = 1'b1;
                        resp_cnt_nxt = resp_cnt + 16'd1;
                        case (cmd[63:56])
                            8'h90: data_out_nxt = chip_byte;
                            8'h00: begin
                                // ROM output for the current address is already
                                // valid; advance so the next byte is ready in time
                                data_out_nxt = hdr_data;
                                hdr_addr_nxt = hdr_addr + ADDR_W'(1);
                            end
                            default: data_out_nxt = 8'hFF;
                        endcase
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntr_cmd_sequencer.sv
// Self-checking bench for ntr_cmd_sequencer: two instances (ADDR_W 9 and 2)
// share one bus; a pin-level model predicts every output each cycle.
`timescale 1ns/1ps
module tb_ntr_cmd_sequencer;

    localparam int S = 2;
    localparam logic [31:0] TB_CHIP_ID = 32'h00001FC2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ntr_clk = 1'b1;
    logic        ntr_cs1 = 1'b1;
    logic [7:0]  data_in = 8'h00;

    logic [7:0]  d_out9, d_out2;
    logic        oe9, oe2;
    logic [8:0]  addr9;
    logic [1:0]  addr2;
    logic [7:0]  hdr9 = 8'h00, hdr2 = 8'h00;
    logic [63:0] cmd9, cmd2;
    logic        valid9, valid2;
    logic        busy9, busy2;

    int checks = 0;
    int errors = 0;
    int nvalid9 = 0;

    logic [7:0] q9[$];
    logic [7:0] q2[$];
    logic [7:0] qoe[$];

    ntr_cmd_sequencer #(.CHIP_ID(32'h00001FC2), .ADDR_W(9), .SYNC_STAGES(S)) dut9 (
        .clk(clk), .rst_n(rst_n), .ntr_clk(ntr_clk), .ntr_cs1(ntr_cs1),
        .data_in(data_in), .data_out(d_out9), .data_oe(oe9), .hdr_addr(addr9),
        .hdr_data(hdr9), .cmd(cmd9), .cmd_valid(valid9), .busy(busy9)
    );

    ntr_cmd_sequencer #(.CHIP_ID(32'h00001FC2), .ADDR_W(2), .SYNC_STAGES(S)) dut2 (
        .clk(clk), .rst_n(rst_n), .ntr_clk(ntr_clk), .ntr_cs1(ntr_cs1),
        .data_in(data_in), .data_out(d_out2), .data_oe(oe2), .hdr_addr(addr2),
        .hdr_data(hdr2), .cmd(cmd2), .cmd_valid(valid2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Header ROMs hold ROM[i] = i, one clk read latency
    always @(posedge clk) begin
        hdr9 <= addr9[7:0];
        hdr2 <= {6'd0, addr2};
    end

    always @(posedge clk) begin
        if (valid9) nvalid9 <= nvalid9 + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_seq(input string nm, input logic [7:0] act[$], input logic [7:0] exp[$]);
        chk({nm, "_len"}, 64'(act.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), 64'(act[i]), 64'(exp[i]));
    endtask

    // ---------------- Behavioural model ----------------
    // Response byte number idx of a transaction whose command byte 0 is op.
    function automatic logic [7:0] exp_byte(input logic [7:0] op, input int idx, input int aw);
        logic [31:0] id;
        id = TB_CHIP_ID;
        if (op == 8'h90) return 8'((id >> (8 * (idx % 4))) & 32'hFF);
        if (op == 8'h00) return 8'((idx % (1 << aw)) % 256);
        return 8'hFF;
    endfunction

    // Pin history: a pin change seen at posedge n acts at posedge n+S.
    logic        hcs[0:S];
    logic        hck[0:S];
    int          m_mode = 0;   // 0 idle, 1 collecting command, 2 responding
    int          m_nb = 0;
    int          m_idx = 0;
    logic [63:0] m_acc = '0;
    logic [7:0]  m_op = '0;
    logic [7:0]  e_out9 = 8'hFF, e_out2 = 8'hFF;
    logic        e_oe = 1'b0, e_busy = 1'b0, e_valid = 1'b0;
    logic [63:0] e_cmd = '0;

    initial begin
        for (int k = 0; k <= S; k++) begin hcs[k] = 1'b0; hck[k] = 1'b0; end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k <= S; k++) begin hcs[k] = 1'b0; hck[k] = 1'b0; end
                m_mode = 0; m_nb = 0; m_idx = 0; m_acc = '0;
                e_out9 = 8'hFF; e_out2 = 8'hFF; e_oe = 1'b0; e_busy = 1'b0;
                e_valid = 1'b0; e_cmd = '0;
            end else begin
                logic cs_r, cs_f, ck_r, ck_f;
                cs_r = hcs[S-1] && !hcs[S];
                cs_f = !hcs[S-1] && hcs[S];
                ck_r = hck[S-1] && !hck[S];
                ck_f = !hck[S-1] && hck[S];
                e_valid = 1'b0;
                if (cs_r) begin
                    m_mode = 0; e_oe = 1'b0; e_busy = 1'b0;
                    e_out9 = 8'hFF; e_out2 = 8'hFF;
                end else if (m_mode == 0) begin
                    if (cs_f) begin m_mode = 1; m_nb = 0; m_acc = '0; e_busy = 1'b1; end
                end else if (m_mode == 1) begin
                    if (ck_r) begin
                        m_acc = {m_acc[55:0], data_in};
                        m_nb++;
                        if (m_nb == 8) begin
                            e_cmd = m_acc; e_valid = 1'b1; m_op = m_acc[63:56];
                            m_idx = 0; m_mode = 2;
                        end
                    end
                end else if (ck_f) begin
                    e_oe = 1'b1;
                    e_out9 = exp_byte(m_op, m_idx, 9);
                    e_out2 = exp_byte(m_op, m_idx, 2);
                    m_idx++;
                end
                for (int k = S; k > 0; k--) begin hcs[k] = hcs[k-1]; hck[k] = hck[k-1]; end
                hcs[0] = ntr_cs1;
                hck[0] = ntr_clk;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("dut9.data_out", 64'(d_out9), 64'(e_out9));
            chk("dut9.data_oe", 64'(oe9), 64'(e_oe));
            chk("dut9.busy", 64'(busy9), 64'(e_busy));
            chk("dut9.cmd_valid", 64'(valid9), 64'(e_valid));
            chk("dut9.cmd", cmd9, e_cmd);
            chk("dut2.data_out", 64'(d_out2), 64'(e_out2));
            chk("dut2.data_oe", 64'(oe2), 64'(e_oe));
            chk("dut2.busy", 64'(busy2), 64'(e_busy));
            chk("dut2.cmd_valid", 64'(valid2), 64'(e_valid));
            chk("dut2.cmd", cmd2, e_cmd);
        end
    end

    // ---------------- Bus driver ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        ntr_clk = 1'b0; data_in = b; cyc(6);
        ntr_clk = 1'b1; cyc(6);
    endtask

    task automatic send_cmd(input logic [63:0] c);
        for (int i = 0; i < 8; i++) send_byte(c[63 - 8*i -: 8]);
    endtask

    task automatic resp_fall();
        ntr_clk = 1'b0; cyc(6);
        q9.push_back(d_out9); q2.push_back(d_out2); qoe.push_back({7'd0, oe9});
        ntr_clk = 1'b1; cyc(6);
    endtask

    task automatic cs_low();
        ntr_cs1 = 1'b0; cyc(6);
    endtask

    task automatic cs_high();
        ntr_cs1 = 1'b1; cyc(4);
        chk("oe_drop_after_cs_rise", 64'(oe9), 64'd0);
        cyc(6);
    endtask

    task automatic clear_q();
        q9.delete(); q2.delete(); qoe.delete();
    endtask

    task automatic run_txn(input logic [63:0] c, input int nfalls);
        clear_q();
        cs_low();
        send_cmd(c);
        repeat (nfalls) resp_fall();
        cs_high();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp[$];
        int v0;

        cyc(3);
        chk("reset_data_out", 64'(d_out9), 64'hFF);
        chk("reset_data_oe", 64'(oe9), 64'd0);
        chk("reset_busy", 64'(busy9), 64'd0);
        chk("reset_cmd", cmd9, 64'd0);
        chk("reset_hdr_addr", 64'(addr9), 64'd0);
        rst_n = 1'b1;
        cyc(10);

        // Chip ID
        run_txn(64'h9000000000000000, 6);
        exp = '{8'hC2, 8'h1F, 8'h00, 8'h00, 8'hC2, 8'h1F};
        chk_seq("chipid", q9, exp);
        exp = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        chk_seq("chipid_oe", qoe, exp);
        chk("chipid_valid_count", 64'(nvalid9), 64'd1);
        chk("chipid_cmd", cmd9, 64'h9000000000000000);

        // Header read, both address widths
        run_txn(64'h0000000000000000, 6);
        exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        chk_seq("hdr_aw9", q9, exp);
        exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h01};
        chk_seq("hdr_aw2", q2, exp);

        // Dummy 0x9F
        run_txn(64'h9F00000000000000, 3);
        exp = '{8'hFF, 8'hFF, 8'hFF};
        chk_seq("dummy9f", q9, exp);
        exp = '{8'h01, 8'h01, 8'h01};
        chk_seq("dummy9f_oe", qoe, exp);
        chk("dummy9f_cmd", cmd9, 64'h9F00000000000000);

        // Unknown 0x3C, cs1 fall coincides with an ntr_clk rise (not sampled)
        clear_q();
        ntr_clk = 1'b0; cyc(6);
        ntr_cs1 = 1'b0; ntr_clk = 1'b1; data_in = 8'hAA; cyc(6);
        send_cmd(64'h3C00000000000000);
        repeat (3) resp_fall();
        cs_high();
        exp = '{8'hFF, 8'hFF, 8'hFF};
        chk_seq("unknown3c", q9, exp);
        chk("unknown3c_cmd", cmd9, 64'h3C00000000000000);
        chk("unknown3c_cmd2", cmd2, 64'h3C00000000000000);

        // Abort after 5 bytes; the 6th rise lands with the cs1 rise
        v0 = nvalid9;
        cs_low();
        send_byte(8'h90); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44);
        ntr_clk = 1'b0; data_in = 8'h55; cyc(6);
        ntr_cs1 = 1'b1; ntr_clk = 1'b1; cyc(10);
        chk("abort_no_valid", 64'(nvalid9), 64'(v0));
        chk("abort_cmd_kept", cmd9, 64'h3C00000000000000);
        chk("abort_oe", 64'(oe9), 64'd0);
        run_txn(64'h9000000000000000, 4);
        exp = '{8'hC2, 8'h1F, 8'h00, 8'h00};
        chk_seq("after_abort", q9, exp);

        // Back-to-back with a 100-cycle gap
        run_txn(64'h9000000000000000, 3);
        exp = '{8'hC2, 8'h1F, 8'h00};
        chk_seq("b2b_first", q9, exp);
        cyc(100);
        run_txn(64'h9000000000000000, 3);
        chk_seq("b2b_second", q9, exp);

        // Reset during the response phase
        cs_low();
        send_cmd(64'h9000000000000000);
        resp_fall(); resp_fall();
        ntr_clk = 1'b0; cyc(6);
        chk("pre_reset_oe", 64'(oe9), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_async_oe", 64'(oe9), 64'd0);
        chk("reset_async_data_out", 64'(d_out9), 64'hFF);
        chk("reset_async_busy", 64'(busy9), 64'd0);
        cyc(3);
        rst_n = 1'b1;
        ntr_clk = 1'b1; cyc(6);
        ntr_clk = 1'b0; cyc(6);
        ntr_clk = 1'b1; cyc(6);
        chk("post_reset_ignored_oe", 64'(oe9), 64'd0);
        chk("post_reset_ignored_busy", 64'(busy9), 64'd0);
        cs_high();
        v0 = nvalid9;
        run_txn(64'h9000000000000000, 2);
        exp = '{8'hC2, 8'h1F};
        chk_seq("post_reset_txn", q9, exp);
        chk("post_reset_valid", 64'(nvalid9), 64'(v0 + 1));

        cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
